// File: rtl/tube_p_pkg.sv
// Shared definitions for the parasite-side tube responder.
// Holds channel indices, status-byte bit positions, the latched strobe
// payload and a helper that extracts the channel from a tube address.
package tube_p_pkg;

  localparam int unsigned NUM_CH = 4;

  // Tube register pair indices (R1..R4).
  localparam logic [1:0] CH_R1 = 2'd0;
  localparam logic [1:0] CH_R2 = 2'd1;
  localparam logic [1:0] CH_R3 = 2'd2;
  localparam logic [1:0] CH_R4 = 2'd3;

  // Status byte bit positions.
  localparam int unsigned ST_AVAIL = 7;
  localparam int unsigned ST_NFULL = 6;
  localparam int unsigned ST_OVF   = 5;

  // Address and write data captured while a strobe is active.
  typedef struct packed {
    logic [2:0] addr;
    logic [7:0] wdat;
  } strobe_lat_t;

  // Channel selected by a tube register address.
  function automatic logic [1:0] addr_chan(input logic [2:0] addr);
    return addr[2:1];
  endfunction

endpackage

// File: rtl/tube_p_responder_if.sv
// Bundle of the tube strobe bus and the host-side byte stream.
// master: tube initiator / host side (drives strobes, host push/pop)
// slave : tube_p_responder
interface tube_p_responder_if;

  // Tube strobe bus
  logic [2:0] p_addr;
  logic       p_cs_b;
  logic       p_rd_b;
  logic       p_wr_b;
  logic [7:0] p_dat_i;
  logic [7:0] p_dat_o;
  logic       p_dat_oe;
  logic       p_irq_b;
  logic       p_nmi_b;
  logic [1:0] irq_en;
  logic       nmi_en;

  // Host-side channel-indexed byte stream
  logic       h_wr_valid;
  logic [1:0] h_wr_chan;
  logic [7:0] h_wr_data;
  logic       h_wr_ready;
  logic [1:0] h_rd_chan;
  logic       h_rd_valid;
  logic [7:0] h_rd_data;
  logic       h_rd_pop;

  modport master (
    output p_addr, p_cs_b, p_rd_b, p_wr_b, p_dat_i, irq_en, nmi_en,
    output h_wr_valid, h_wr_chan, h_wr_data, h_rd_chan, h_rd_pop,
    input  p_dat_o, p_dat_oe, p_irq_b, p_nmi_b,
    input  h_wr_ready, h_rd_valid, h_rd_data
  );

  modport slave (
    input  p_addr, p_cs_b, p_rd_b, p_wr_b, p_dat_i, irq_en, nmi_en,
    input  h_wr_valid, h_wr_chan, h_wr_data, h_rd_chan, h_rd_pop,
    output p_dat_o, p_dat_oe, p_irq_b, p_nmi_b,
    output h_wr_ready, h_rd_valid, h_rd_data
  );

endinterface

// File: rtl/tube_p_responder_byte_fifo.sv
// Byte FIFO used for every H2P and P2H register pair queue.
// Ports: clk, rst (sync, active-high); push/din write when not full;
//        pop advances head when not empty; head/empty/full/count status.
// Push and pop in the same cycle both apply; count is unchanged.
module byte_fifo #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [7:0]                 din,
  input  logic                       pop,
  output logic [7:0]                 head,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   cnt;
  logic          do_push;
  logic          do_pop;

  assign empty   = (cnt == '0);
  assign full    = (cnt == FULL_CNT);
  assign count   = cnt;
  assign head    = mem[rd_ptr];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Storage has no reset; head is only meaningful when not empty.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (AW+1)'(1);
        2'b01:   cnt <= cnt - (AW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/tube_p_responder.sv
// Parasite-side responder for the 8-bit tube strobe bus.
// Four register pairs, each with an H2P and a P2H byte FIFO. The parasite
// reads H2P/writes P2H over the strobe bus; the host pushes H2P and pops P2H.
// Ports: clk, rst (sync, active-high), bus (tube_p_responder_if.slave):
//   p_addr/p_cs_b/p_rd_b/p_wr_b/p_dat_i -> strobe bus in
//   p_dat_o/p_dat_oe                   -> combinational read data / enable
//   p_irq_b/p_nmi_b                    -> registered interrupts
//   irq_en/nmi_en                      -> interrupt source enables
//   h_wr_*/h_rd_*                      -> host byte stream
module tube_p_responder
  import tube_p_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input logic              clk,
  input logic              rst,
  tube_p_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  // Strobe tracking
  logic        rd_act;
  logic        wr_act;
  logic        rd_q;
  logic        wr_q;
  logic        rd_blk;
  logic        wr_blk;
  logic        rd_end;
  logic        wr_end;
  strobe_lat_t lat_q;
  logic [1:0]  lat_ch;
  logic        lat_odd;

  // FIFO status
  logic [NUM_CH-1:0] h2p_push, h2p_pop, h2p_empty, h2p_full;
  logic [NUM_CH-1:0] p2h_push, p2h_pop, p2h_empty, p2h_full;
  logic [7:0]        h2p_head  [NUM_CH];
  logic [7:0]        p2h_head  [NUM_CH];
  logic [AW:0]       h2p_count [NUM_CH];
  logic [AW:0]       p2h_count [NUM_CH];

  logic [NUM_CH-1:0] ovf;
  logic              irq_q;
  logic              nmi_q;
  logic [7:0]        rd_mux;
  logic [1:0]        bus_ch;

  assign rd_act  = ~bus.p_cs_b & ~bus.p_rd_b;
  assign wr_act  = ~bus.p_cs_b & ~bus.p_wr_b;
  assign rd_end  = rd_q & ~rd_act;
  assign wr_end  = wr_q & ~wr_act;
  assign lat_ch  = addr_chan(lat_q.addr);
  assign lat_odd = lat_q.addr[0];
  assign bus_ch  = addr_chan(bus.p_addr);

  // A strobe already active when reset releases stays blocked until it
  // drops, so only strobes that start after reset can raise an end event.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      rd_blk <= 1'b1;
      wr_blk <= 1'b1;
      lat_q  <= '0;
    end else begin
      rd_q   <= rd_act & ~rd_blk;
      wr_q   <= wr_act & ~wr_blk;
      rd_blk <= rd_blk & rd_act;
      wr_blk <= wr_blk & wr_act;
      if (rd_act | wr_act) lat_q.addr <= bus.p_addr;
      if (wr_act)          lat_q.wdat <= bus.p_dat_i;
    end
  end

  // FIFO push/pop decode for both sides.
  always_comb begin
    h2p_push = '0;
    h2p_pop  = '0;
    p2h_push = '0;
    p2h_pop  = '0;
    h2p_push[bus.h_wr_chan] = bus.h_wr_valid & ~h2p_full[bus.h_wr_chan];
    h2p_pop[lat_ch]         = rd_end & lat_odd & ~h2p_empty[lat_ch];
    p2h_push[lat_ch]        = wr_end & lat_odd & ~p2h_full[lat_ch];
    p2h_pop[bus.h_rd_chan]  = bus.h_rd_pop & ~p2h_empty[bus.h_rd_chan];
  end

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    byte_fifo #(.DEPTH(DEPTH)) u_h2p (
      .clk   (clk),
      .rst   (rst),
      .push  (h2p_push[g]),
      .din   (bus.h_wr_data),
      .pop   (h2p_pop[g]),
      .head  (h2p_head[g]),
      .empty (h2p_empty[g]),
      .full  (h2p_full[g]),
      .count (h2p_count[g])
    );

    byte_fifo #(.DEPTH(DEPTH)) u_p2h (
      .clk   (clk),
      .rst   (rst),
      .push  (p2h_push[g]),
      .din   (lat_q.wdat),
      .pop   (p2h_pop[g]),
      .head  (p2h_head[g]),
      .empty (p2h_empty[g]),
      .full  (p2h_full[g]),
      .count (p2h_count[g])
    );
  end

  // Sticky overflow: set on a dropped P2H write, cleared by a status read.
  // A set in the same cycle as a clear on that channel wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= '0;
    end else begin
      if (rd_end & ~lat_odd)                     ovf[lat_ch] <= 1'b0;
      if (wr_end & lat_odd & p2h_full[lat_ch])   ovf[lat_ch] <= 1'b1;
    end
  end

  // Interrupts follow FIFO state one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q <= 1'b1;
      nmi_q <= 1'b1;
    end else begin
      irq_q <= ~((bus.irq_en[0] & ~h2p_empty[CH_R1]) |
                 (bus.irq_en[1] & ~h2p_empty[CH_R4]));
      nmi_q <= ~(bus.nmi_en & ~h2p_empty[CH_R3]);
    end
  end

  // Read data from the current address: status on even, H2P head on odd.
  always_comb begin
    rd_mux = '0;
    if (bus.p_addr[0]) begin
      rd_mux = h2p_empty[bus_ch] ? 8'h00 : h2p_head[bus_ch];
    end else begin
      rd_mux[ST_AVAIL] = ~h2p_empty[bus_ch];
      rd_mux[ST_NFULL] = (p2h_count[bus_ch] != FULL_CNT);
      rd_mux[ST_OVF]   = ovf[bus_ch];
    end
  end

  assign bus.p_dat_oe = rd_act;
  assign bus.p_dat_o  = rd_act ? rd_mux : 8'h00;
  assign bus.p_irq_b  = irq_q;
  assign bus.p_nmi_b  = nmi_q;

  // Host side: ready depends on count only, so a full FIFO is not ready
  // even if a parasite pop happens in the same cycle.
  assign bus.h_wr_ready = (h2p_count[bus.h_wr_chan] != FULL_CNT);
  assign bus.h_rd_valid = ~p2h_empty[bus.h_rd_chan];
  assign bus.h_rd_data  = p2h_empty[bus.h_rd_chan] ? 8'h00 : p2h_head[bus.h_rd_chan];

endmodule

// File: tb/tb_tube_p_responder.sv
// Scoreboard bench for tube_p_responder: queue-based reference model of the
// eight FIFOs and overflow flags, directed scenarios plus random traffic.
module tb_tube_p_responder;
  import tube_p_pkg::*;

  localparam int unsigned DEPTH = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  tube_p_responder_if bus();

  tube_p_responder #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [7:0] h2p_m [4][$];
  logic [7:0] p2h_m [4][$];
  logic       ovf_m [4];

  // Scoreboard queues
  logic [7:0] exp_par [$];
  logic [7:0] exp_host [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      h2p_m[i].delete();
      p2h_m[i].delete();
      ovf_m[i] = 1'b0;
    end
  endtask

  // Monitor: compares whenever the DUT presents read data.
  logic oe_prev = 1'b0;
  always @(negedge clk) begin
    if (bus.p_dat_oe && !oe_prev) begin
      if (exp_par.size() == 0) begin
        checks++; errors++;
        $display("FAIL p_dat_o: got %0h with no read expected", bus.p_dat_o);
      end else begin
        chk("p_dat_o", 32'(bus.p_dat_o), 32'(exp_par.pop_front()));
      end
    end
    oe_prev = bus.p_dat_oe;
    if (bus.h_rd_pop && bus.h_rd_valid) begin
      if (exp_host.size() == 0) begin
        checks++; errors++;
        $display("FAIL h_rd_data: got %0h with no pop expected", bus.h_rd_data);
      end else begin
        chk("h_rd_data", 32'(bus.h_rd_data), 32'(exp_host.pop_front()));
      end
    end
  end

  task automatic check_ints();
    logic ei, en;
    ei = !((bus.irq_en[0] && h2p_m[0].size() > 0) || (bus.irq_en[1] && h2p_m[3].size() > 0));
    en = !(bus.nmi_en && h2p_m[2].size() > 0);
    chk("p_irq_b", 32'(bus.p_irq_b), 32'(ei));
    chk("p_nmi_b", 32'(bus.p_nmi_b), 32'(en));
  endtask

  task automatic host_push(input logic [1:0] ch, input logic [7:0] d);
    logic rdy;
    step();
    bus.h_wr_chan  = ch;
    bus.h_wr_data  = d;
    bus.h_wr_valid = 1'b1;
    #1;
    rdy = (h2p_m[ch].size() < DEPTH);
    chk("h_wr_ready", 32'(bus.h_wr_ready), 32'(rdy));
    if (rdy) h2p_m[ch].push_back(d);
    step();
    bus.h_wr_valid = 1'b0;
    step();
  endtask

  task automatic host_pop(input logic [1:0] ch);
    step();
    bus.h_rd_chan = ch;
    bus.h_rd_pop  = 1'b1;
    #1;
    chk("h_rd_valid", 32'(bus.h_rd_valid), 32'(p2h_m[ch].size() > 0));
    if (p2h_m[ch].size() > 0) exp_host.push_back(p2h_m[ch].pop_front());
    step();
    bus.h_rd_pop = 1'b0;
    step();
  endtask

  // Parasite read; optionally a host push lands on the end-of-strobe edge.
  task automatic par_read(input logic [2:0] addr, input bit push_en,
                          input logic [1:0] push_ch, input logic [7:0] push_d);
    logic [1:0] ch;
    logic [7:0] e;
    bit rdy;
    ch = addr[2:1];
    if (addr[0]) e = (h2p_m[ch].size() > 0) ? h2p_m[ch][0] : 8'h00;
    else e = {h2p_m[ch].size() > 0, p2h_m[ch].size() < DEPTH, ovf_m[ch], 5'b0};
    exp_par.push_back(e);
    step();
    bus.p_addr = addr;
    bus.p_cs_b = 1'b0;
    bus.p_rd_b = 1'b0;
    step();
    step();
    bus.p_cs_b = 1'b1;
    bus.p_rd_b = 1'b1;
    if (push_en) begin
      bus.h_wr_chan  = push_ch;
      bus.h_wr_data  = push_d;
      bus.h_wr_valid = 1'b1;
    end
    step();
    bus.h_wr_valid = 1'b0;
    rdy = push_en && (h2p_m[push_ch].size() < DEPTH);
    if (addr[0]) begin
      if (h2p_m[ch].size() > 0) void'(h2p_m[ch].pop_front());
    end else begin
      ovf_m[ch] = 1'b0;
    end
    if (rdy) h2p_m[push_ch].push_back(push_d);
    step();
  endtask

  // Parasite write; data changes mid-strobe, the last sampled value counts.
  task automatic par_write(input logic [2:0] addr, input logic [7:0] d);
    logic [1:0] ch;
    ch = addr[2:1];
    step();
    bus.p_addr  = addr;
    bus.p_dat_i = ~d;
    bus.p_cs_b  = 1'b0;
    bus.p_wr_b  = 1'b0;
    step();
    bus.p_dat_i = d;
    step();
    bus.p_cs_b  = 1'b1;
    bus.p_wr_b  = 1'b1;
    bus.p_dat_i = 8'($urandom);
    step();
    if (addr[0]) begin
      if (p2h_m[ch].size() < DEPTH) p2h_m[ch].push_back(d);
      else ovf_m[ch] = 1'b1;
    end
    step();
  endtask

  task automatic check_reset_outputs();
    bus.h_wr_chan = 2'd0;
    bus.h_rd_chan = 2'd0;
    #1;
    chk("rst_p_dat_oe", 32'(bus.p_dat_oe), 0);
    chk("rst_p_dat_o", 32'(bus.p_dat_o), 0);
    chk("rst_p_irq_b", 32'(bus.p_irq_b), 1);
    chk("rst_p_nmi_b", 32'(bus.p_nmi_b), 1);
    chk("rst_h_wr_ready", 32'(bus.h_wr_ready), 1);
    chk("rst_h_rd_valid", 32'(bus.h_rd_valid), 0);
    chk("rst_h_rd_data", 32'(bus.h_rd_data), 0);
  endtask

  initial begin
    #600000;
    errors++;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.p_addr = 3'd0; bus.p_cs_b = 1'b1; bus.p_rd_b = 1'b1; bus.p_wr_b = 1'b1;
    bus.p_dat_i = 8'h00; bus.irq_en = 2'b00; bus.nmi_en = 1'b0;
    bus.h_wr_valid = 1'b0; bus.h_wr_chan = 2'd0; bus.h_wr_data = 8'h00;
    bus.h_rd_chan = 2'd0; bus.h_rd_pop = 1'b0;
    model_clear();
    repeat (3) step();
    rst = 1'b0;
    step();
    check_reset_outputs();

    // IRQ from R1 and its one-cycle latency
    host_push(CH_R1, 8'hA5);
    par_read(3'd0, 0, 2'd0, 8'h00);
    check_ints();
    step();
    bus.irq_en = 2'b01;
    #1;
    chk("irq_latency", 32'(bus.p_irq_b), 1);
    step();
    check_ints();
    par_read(3'd1, 0, 2'd0, 8'h00);
    par_read(3'd0, 0, 2'd0, 8'h00);
    check_ints();

    // P2H overflow on R2, host drains, status read clears overflow
    for (int i = 1; i <= 5; i++) par_write(3'd3, 8'(8'h11 * i));
    par_read(3'd2, 0, 2'd0, 8'h00);
    for (int i = 0; i < 4; i++) host_pop(CH_R2);
    host_pop(CH_R2);
    par_read(3'd2, 0, 2'd0, 8'h00);
    par_read(3'd2, 0, 2'd0, 8'h00);

    // Empty data read on R3, then NMI until the byte is consumed
    par_read(3'd5, 0, 2'd0, 8'h00);
    bus.nmi_en = 1'b1;
    host_push(CH_R3, 8'h7E);
    check_ints();
    par_read(3'd4, 0, 2'd0, 8'h00);
    check_ints();
    par_read(3'd5, 0, 2'd0, 8'h00);
    check_ints();

    // Concurrent host push and parasite pop on R4
    host_push(CH_R4, 8'hC1);
    host_push(CH_R4, 8'hC2);
    par_read(3'd7, 1, CH_R4, 8'hC3);
    par_read(3'd6, 0, 2'd0, 8'h00);
    for (int i = 0; i < 3; i++) par_read(3'd7, 0, 2'd0, 8'h00);

    // H2P full on R2: fifth push ignored
    for (int i = 0; i < 5; i++) host_push(CH_R2, 8'(8'hB0 + i));
    for (int i = 0; i < 5; i++) par_read(3'd3, 0, 2'd0, 8'h00);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        bus.irq_en = 2'($urandom);
        bus.nmi_en = 1'($urandom);
      end
      case ($urandom_range(0, 3))
        0: host_push(2'($urandom), 8'($urandom));
        1: host_pop(2'($urandom));
        2: par_read(3'($urandom), 1'($urandom), 2'($urandom), 8'($urandom));
        default: par_write(3'($urandom), 8'($urandom));
      endcase
      check_ints();
    end

    // Reset in the middle of a write strobe to addr 1
    step();
    bus.p_addr  = 3'd1;
    bus.p_dat_i = 8'h99;
    bus.p_cs_b  = 1'b0;
    bus.p_wr_b  = 1'b0;
    step();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    model_clear();
    step();
    step();
    bus.p_cs_b = 1'b1;
    bus.p_wr_b = 1'b1;
    step();
    step();
    check_reset_outputs();

    // A fresh strobe after reset is acted upon
    par_write(3'd1, 8'h5C);
    host_pop(CH_R1);
    host_pop(CH_R1);

    repeat (3) step();
    chk("par_queue_drained", 32'(exp_par.size()), 0);
    chk("host_queue_drained", 32'(exp_host.size()), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
